// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract engine: one full-adder cell, registered carry,
// operands and result exchanged over valid/ready handshakes.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid/in_ready           operand handshake (a, b, cin, sub)
//   out_valid/out_ready         result handshake (sum, cout, ovf)
//   busy                        high while in RUN or DONE
//   zero                        result-is-zero flag, present only when
//                               SERIAL_ADDER_ZERO_FLAG_EN is defined
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
    output logic             zero,
`endif
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rega_q, rega_d;
    logic [WIDTH-1:0] regb_q, regb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] res_next;

    // The single full-adder cell.
    assign fa_s = rega_q[0] ^ regb_q[0] ^ carry_q;
    assign fa_c = (rega_q[0] & regb_q[0])
                | (rega_q[0] & carry_q)
                | (regb_q[0] & carry_q);

    // Result register after shifting in the current sum bit at the MSB.
    assign res_next = {fa_s, res_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rega_q  <= '0;
            regb_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rega_q  <= rega_d;
            regb_q  <= regb_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rega_d  = rega_q;
        regb_d  = regb_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction is a + ~b + 1: invert b, force carry-in.
                    rega_d  = a;
                    regb_d  = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d   = res_next;
                rega_d  = rega_q >> 1;
                regb_d  = regb_q >> 1;
                carry_d = fa_c;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // carry_q here is the carry into the MSB.
                    sum_d   = res_next;
                    cout_d  = fa_c;
                    ovf_d   = carry_q ^ fa_c;
                    zero_d  = ~|res_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

`ifdef SERIAL_ADDER_ZERO_FLAG_EN
    assign zero = zero_q;
`else
    logic unused_zero;
    assign unused_zero = zero_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed testbench for serial_adder_ctrl (WIDTH=8).
// Immediate assertions at each comparison point; one summary line at the end.
module tb_serial_adder_ctrl;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic       busy;
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
    logic       zero;
`endif

    int checks   = 0;
    int failures = 0;
    int lat;
    logic seen_valid;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
        .zero      (zero),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands for one accept edge, then scramble the inputs.
    task automatic start(input logic [7:0] ta, input logic [7:0] tb_v,
                         input logic tcin, input logic tsub);
        a = ta;
        b = tb_v;
        cin = tcin;
        sub = tsub;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = 8'hA5;
        b = 8'h5A;
        cin = ~tcin;
        sub = ~tsub;
    endtask

    // Count edges after the accept edge until out_valid, bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic ack();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic op(input string tag, input logic [7:0] ta,
                      input logic [7:0] tb_v, input logic tcin,
                      input logic tsub, input logic [7:0] es,
                      input logic ec, input logic eo);
        start(ta, tb_v, tcin, tsub);
        chk({tag, "_in_ready_run"}, in_ready, 1'b0);
        wait_done(lat);
        chk({tag, "_latency"}, lat, 8);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, cout, ec);
        chk({tag, "_ovf"}, ovf, eo);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        sub = 1'b0;
        out_ready = 1'b0;

        tick();
        tick();
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sum", sum, 8'h00);
        chk("rst_cout", cout, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
        chk("rst_zero", zero, 1'b0);
`endif
        rst = 1'b0;
        tick();

        op("add0f01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
        chk("add0f01_busy", busy, 1'b1);
        chk("add0f01_in_ready_done", in_ready, 1'b0);
        ack();
        chk("ack_in_ready", in_ready, 1'b1);
        chk("ack_out_valid", out_valid, 1'b0);
        chk("hold_idle_sum", sum, 8'h10);

        op("addff01c", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
        ack();

        start(8'h7F, 8'h01, 1'b0, 1'b0);
        chk("hold_run_sum", sum, 8'h01);
        chk("hold_run_cout", cout, 1'b1);
        wait_done(lat);
        chk("add7f01_latency", lat, 8);
        chk("add7f01_sum", sum, 8'h80);
        chk("add7f01_cout", cout, 1'b0);
        chk("add7f01_ovf", ovf, 1'b1);
        ack();

        op("sub0507", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
        chk("sub0507_zero", zero, 1'b0);
`endif
        ack();

        op("sub3333", 8'h33, 8'h33, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
        chk("sub3333_zero", zero, 1'b1);
`endif

        // Backpressure: DONE held, in_valid offered but not taken.
        in_valid = 1'b1;
        a = 8'h11;
        b = 8'h22;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_sum", sum, 8'h00);
            chk("bp_cout", cout, 1'b1);
        end
        in_valid = 1'b0;
        ack();
        chk("bp_release_in_ready", in_ready, 1'b1);
        chk("bp_release_out_valid", out_valid, 1'b0);

        op("add8080", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        ack();

        op("add1234", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);
        ack();

        // Reset sampled at the 4th RUN edge.
        start(8'h55, 8'h11, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_sum", sum, 8'h00);
        seen_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) seen_valid = 1'b1;
        end
        chk("midrst_no_valid", seen_valid, 1'b0);

        op("add1020", 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0);
        ack();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
